// File: rtl/crack_pkg.sv
// Shared constants, FSM states and job-range helpers for the crack dispatcher.
package crack_pkg;

  localparam int         CHAR_BASE = 48;
  localparam int         RADIX     = 36;
  localparam int         PWD_CHARS = 4;
  localparam logic [7:0] CHAR_MAX  = 8'h53;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN,
    FINISH
  } state_t;

  function automatic logic [5:0] chunk_from(input logic [5:0] job, input int chunk);
    int v;
    v = int'(job) * chunk;
    if (v > RADIX - 1) v = RADIX - 1;
    return 6'(v);
  endfunction

  // Last first-digit value of a job, clipped to the top of the radix.
  function automatic logic [5:0] chunk_to(input logic [5:0] job, input int chunk);
    int v;
    v = int'(job) * chunk + chunk - 1;
    if (v > RADIX - 1) v = RADIX - 1;
    return 6'(v);
  endfunction

endpackage

// File: rtl/crack_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module crack_prio_enc #(
  parameter int W     = 4,
  parameter int IDX_W = 3
) (
  input  logic [W-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/crack_dispatcher.sv
// Splits the first-digit search space into jobs, hands them to idle workers
// and folds the workers' found/done flags into one search result.
module crack_dispatcher
  import crack_pkg::*;
#(
  parameter int NUM_WORKERS = 4,
  parameter int CHUNK       = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [31:0]              i_password_in,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_found,
  output logic                     o_error,
  output logic [2:0]               o_found_worker,
  output logic [5:0]               o_found_from,
  output logic [31:0]              o_cycle_count,
  output logic [NUM_WORKERS-1:0]   o_wk_rst,
  output logic [32:0]              o_wk_password,
  output logic [6*NUM_WORKERS-1:0] o_wk_from,
  output logic [6*NUM_WORKERS-1:0] o_wk_to,
  input  logic [NUM_WORKERS-1:0]   i_wk_found,
  input  logic [NUM_WORKERS-1:0]   i_wk_done
);

  localparam int         NUM_JOBS = (RADIX + CHUNK - 1) / CHUNK;
  localparam logic [5:0] JOBS_END = 6'(NUM_JOBS);

  state_t r_state;
  state_t w_nextState;

  logic [31:0]            r_pwd;
  logic [5:0]             r_job;
  logic [NUM_WORKERS-1:0] r_wkBusy;
  logic [1:0]             r_blank [NUM_WORKERS];
  logic [5:0]             r_wkFrom [NUM_WORKERS];
  logic [5:0]             r_wkTo [NUM_WORKERS];
  logic                   r_busy;
  logic                   r_done;
  logic                   r_found;
  logic                   r_error;
  logic [2:0]             r_foundWorker;
  logic [5:0]             r_foundFrom;
  logic [31:0]            r_cycleCount;

  logic [NUM_WORKERS-1:0] w_live;
  logic [NUM_WORKERS-1:0] w_hitReq;
  logic [NUM_WORKERS-1:0] w_doneReq;
  logic [NUM_WORKERS-1:0] w_issueOneHot;
  logic [2:0]             w_idleIdx;
  logic                   w_idleValid;
  logic [2:0]             w_hitIdx;
  logic                   w_hitValid;
  logic                   w_jobsLeft;
  logic                   w_issue;
  logic                   w_exhausted;
  logic                   w_pwdBad;
  logic [5:0]             w_issueFrom;
  logic [5:0]             w_issueTo;
  logic [5:0]             w_hitFrom;

  crack_prio_enc #(.W(NUM_WORKERS), .IDX_W(3)) u_idleEnc (
    .i_req   (~r_wkBusy),
    .o_idx   (w_idleIdx),
    .o_valid (w_idleValid)
  );

  crack_prio_enc #(.W(NUM_WORKERS), .IDX_W(3)) u_hitEnc (
    .i_req   (w_hitReq),
    .o_idx   (w_hitIdx),
    .o_valid (w_hitValid)
  );

  assign w_hitReq    = w_live & i_wk_found;
  assign w_doneReq   = w_live & i_wk_done & ~i_wk_found;
  assign w_jobsLeft  = (r_job < JOBS_END);
  assign w_issue     = (r_state == RUN) && !w_hitValid && w_jobsLeft && w_idleValid;
  assign w_exhausted = (r_state == RUN) && !w_hitValid && !w_jobsLeft && (r_wkBusy == '0);
  assign w_issueFrom = chunk_from(r_job, CHUNK);
  assign w_issueTo   = chunk_to(r_job, CHUNK);

  // The range ports show the new job during the issue cycle, then hold it.
  for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_wk
    assign w_live[g]          = r_wkBusy[g] && (r_blank[g] == 2'd0);
    assign w_issueOneHot[g]   = w_issue && (w_idleIdx == 3'(g));
    assign o_wk_from[6*g +: 6] = w_issueOneHot[g] ? w_issueFrom : r_wkFrom[g];
    assign o_wk_to[6*g +: 6]   = w_issueOneHot[g] ? w_issueTo   : r_wkTo[g];
  end

  always_comb begin
    w_hitFrom = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (w_hitIdx == 3'(i)) w_hitFrom = r_wkFrom[i];
    end
  end

  always_comb begin
    w_pwdBad = 1'b0;
    for (int c = 0; c < PWD_CHARS; c++) begin
      if (r_pwd[8*c +: 8] < 8'(CHAR_BASE) || r_pwd[8*c +: 8] > CHAR_MAX) w_pwdBad = 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = CHECK;
      CHECK:   w_nextState = w_pwdBad ? IDLE : RUN;
      RUN:     if (w_hitValid || w_exhausted) w_nextState = FINISH;
      FINISH:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pwd         <= '0;
      r_job         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_error       <= 1'b0;
      r_foundWorker <= '0;
      r_foundFrom   <= '0;
      r_cycleCount  <= '0;
    end else begin
      if (r_state != IDLE && r_cycleCount != '1) r_cycleCount <= r_cycleCount + 32'd1;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_pwd         <= i_password_in;
            r_job         <= '0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_error       <= 1'b0;
            r_foundWorker <= '0;
            r_foundFrom   <= '0;
            r_cycleCount  <= '0;
          end
        end
        CHECK: begin
          if (w_pwdBad) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          if (w_hitValid) begin
            r_found       <= 1'b1;
            r_foundWorker <= w_hitIdx;
            r_foundFrom   <= w_hitFrom;
          end else if (w_issue) begin
            r_job <= r_job + 6'd1;
          end
        end
        FINISH: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Blanking hides a worker's stale flags for two cycles after each load.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wkBusy <= '0;
      for (int i = 0; i < NUM_WORKERS; i++) begin
        r_blank[i]  <= '0;
        r_wkFrom[i] <= '0;
        r_wkTo[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_WORKERS; i++) begin
        if (r_state == IDLE && i_start) begin
          r_wkBusy[i] <= 1'b0;
          r_blank[i]  <= '0;
        end else if (w_issueOneHot[i]) begin
          r_wkBusy[i] <= 1'b1;
          r_blank[i]  <= 2'd2;
          r_wkFrom[i] <= w_issueFrom;
          r_wkTo[i]   <= w_issueTo;
        end else begin
          if (r_blank[i] != 2'd0) r_blank[i] <= r_blank[i] - 2'd1;
          if (r_state == RUN && !w_hitValid && w_doneReq[i]) r_wkBusy[i] <= 1'b0;
        end
      end
    end
  end

  assign o_wk_rst       = !i_rst ? '1 : w_issueOneHot;
  assign o_wk_password  = {1'b0, r_pwd};
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_found        = r_found;
  assign o_error        = r_error;
  assign o_found_worker = r_foundWorker;
  assign o_found_from   = r_foundFrom;
  assign o_cycle_count  = r_cycleCount;

endmodule

// File: tb/tb_crack_dispatcher.sv
// Scoreboard bench: behavioural workers, a job-order checker on every load
// and a result monitor that pops the expected outcome on each rising done.
module tb_crack_dispatcher;

  localparam int NW      = 4;
  localparam int CH      = 4;
  localparam int NJOBS   = (36 + CH - 1) / CH;
  localparam int TIMEOUT = 2000;

  typedef enum int {WM_REAL, WM_FORCE, WM_NEVER} workerMode_t;
  typedef struct {
    bit err;
    bit found;
    int worker;
    int from;
    int minIssued;
  } expect_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [31:0]    passwordIn = '0;
  logic           busy, done, found, error;
  logic [2:0]     foundWorker;
  logic [5:0]     foundFrom;
  logic [31:0]    cycleCount;
  logic [NW-1:0]  wkRst;
  logic [32:0]    wkPassword;
  logic [6*NW-1:0] wkFromBus, wkToBus;
  logic [NW-1:0]  wkFound = '0;
  logic [NW-1:0]  wkDone = '0;

  always #5 clk = ~clk;

  crack_dispatcher #(.NUM_WORKERS(NW), .CHUNK(CH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_password_in  (passwordIn),
    .o_busy         (busy),
    .o_done         (done),
    .o_found        (found),
    .o_error        (error),
    .o_found_worker (foundWorker),
    .o_found_from   (foundFrom),
    .o_cycle_count  (cycleCount),
    .o_wk_rst       (wkRst),
    .o_wk_password  (wkPassword),
    .o_wk_from      (wkFromBus),
    .o_wk_to        (wkToBus),
    .i_wk_found     (wkFound),
    .i_wk_done      (wkDone)
  );

  int          vectorCount = 0;
  int          miscompareCount = 0;
  int          cycleNo = 0;
  int          acceptCycle = 0;
  int          issuedJobs = 0;
  int          lastExpCycles = 0;
  logic [31:0] expPwd = '0;
  expect_t     expQ[$];
  expect_t     curExp;
  bit          prevDone = 1'b0;

  workerMode_t workerMode = WM_REAL;
  int          fixedLat [NW];
  bit          forceHit [NW];
  bit          wkActive [NW];
  bit          wkStale [NW];
  bit          wkHit [NW];
  int          wkCnt [NW];
  int          lastIssue [NW];
  int          mFrom, mTo, mIdx;

  always @(posedge clk) cycleNo++;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural workers: load on wk_rst, keep old flags one more cycle,
  // then report after a latency. Every load is checked against job order.
  always @(negedge clk) begin
    for (int i = 0; i < NW; i++) begin
      if (!rst) begin
        wkActive[i]  = 1'b0;
        wkStale[i]   = 1'b0;
        wkFound[i]   = 1'b0;
        wkDone[i]    = 1'b0;
        lastIssue[i] = -100;
      end else if (wkRst[i]) begin
        mFrom = int'(wkFromBus[6*i +: 6]);
        mTo   = int'(wkToBus[6*i +: 6]);
        checkOutput("issue_from", longint'(mFrom), longint'(CH * issuedJobs));
        checkOutput("issue_to", longint'(mTo),
                    longint'((CH * issuedJobs + CH - 1 > 35) ? 35 : CH * issuedJobs + CH - 1));
        checkOutput("issue_count_ok", longint'(issuedJobs < NJOBS), 1);
        checkOutput("issue_gap_ok", longint'(cycleNo - lastIssue[i] >= 3), 1);
        checkOutput("wk_password", longint'(wkPassword), longint'({1'b0, expPwd}));
        lastIssue[i] = cycleNo;
        issuedJobs++;
        mIdx = int'(wkPassword[31:24]) - 48;
        wkActive[i] = 1'b1;
        wkStale[i]  = 1'b1;
        wkCnt[i]    = (fixedLat[i] > 0) ? fixedLat[i] : int'($urandom_range(1, 8));
        case (workerMode)
          WM_REAL:  wkHit[i] = (mIdx >= mFrom) && (mIdx <= mTo);
          WM_FORCE: wkHit[i] = forceHit[i];
          default:  wkHit[i] = 1'b0;
        endcase
      end else if (wkActive[i]) begin
        if (wkStale[i]) begin
          wkStale[i] = 1'b0;
          wkFound[i] = 1'b0;
          wkDone[i]  = 1'b0;
        end
        wkCnt[i]--;
        if (wkCnt[i] <= 0) begin
          wkActive[i] = 1'b0;
          wkDone[i]   = 1'b1;
          wkFound[i]  = wkHit[i];
        end
      end
    end
  end

  // Result monitor: one expected outcome per accepted start.
  always @(negedge clk) begin
    if (rst && done && !prevDone) begin
      checkOutput("result_expected", longint'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        curExp = expQ.pop_front();
        lastExpCycles = cycleNo - acceptCycle;
        checkOutput("res_error", longint'(error), longint'(curExp.err));
        checkOutput("res_found", longint'(found), longint'(curExp.found));
        checkOutput("res_busy", longint'(busy), 0);
        checkOutput("res_cycles", longint'(cycleCount), longint'(lastExpCycles));
        if (curExp.found) begin
          checkOutput("res_from", longint'(foundFrom), longint'(curExp.from));
          if (curExp.worker >= 0)
            checkOutput("res_worker", longint'(foundWorker), longint'(curExp.worker));
          checkOutput("res_issued_min", longint'(issuedJobs >= curExp.minIssued), 1);
        end else begin
          checkOutput("res_issued", longint'(issuedJobs), longint'(curExp.minIssued));
        end
      end
    end
    prevDone = rst ? done : 1'b0;
  end

  function automatic expect_t buildExpect(input logic [31:0] pwd);
    expect_t e;
    logic [7:0] ch;
    int job;
    e.err = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ch = pwd[8*c +: 8];
      if (ch < 8'h30 || ch > 8'h53) e.err = 1'b1;
    end
    e.found = 1'b0;
    e.worker = -1;
    e.from = -1;
    e.minIssued = 0;
    if (!e.err) begin
      case (workerMode)
        WM_REAL: begin
          job = (int'(pwd[31:24]) - 48) / CH;
          e.found = 1'b1;
          e.from = job * CH;
          e.worker = (job < NW) ? job : -1;
          e.minIssued = job + 1;
        end
        WM_FORCE: begin
          for (int k = NW - 1; k >= 0; k--) if (forceHit[k]) e.worker = k;
          e.found = 1'b1;
          e.from = e.worker * CH;
          e.minIssued = e.worker + 1;
        end
        default: e.minIssued = NJOBS;
      endcase
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [31:0] pwd);
    expect_t e;
    e = buildExpect(pwd);
    @(negedge clk);
    passwordIn = pwd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expPwd = pwd;
    acceptCycle = cycleNo;
    issuedJobs = 0;
    expQ.push_back(e);
  endtask

  task automatic waitDone(input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_wait_ok", longint'(n <= maxCycles && expQ.size() == 0), 1);
    expQ.delete();
    repeat (3) @(negedge clk);
    checkOutput("done_held", longint'(done), 1);
    checkOutput("cycles_frozen", longint'(cycleCount), longint'(lastExpCycles));
  endtask

  task automatic pulseIgnoredStart(input logic [31:0] pwd);
    passwordIn = pwd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_flags", longint'({busy, done, found, error}), 0);
    checkOutput("rst_found_worker", longint'(foundWorker), 0);
    checkOutput("rst_found_from", longint'(foundFrom), 0);
    checkOutput("rst_cycle_count", longint'(cycleCount), 0);
    checkOutput("rst_wk_from", longint'(wkFromBus), 0);
    checkOutput("rst_wk_to", longint'(wkToBus), 0);
    checkOutput("rst_wk_password", longint'(wkPassword), 0);
    checkOutput("rst_wk_rst", longint'(wkRst), longint'((1 << NW) - 1));
  endtask

  function automatic logic [31:0] randomPassword();
    logic [31:0] p;
    int pos;
    for (int c = 0; c < 4; c++) p[8*c +: 8] = 8'($urandom_range(0, 35) + 48);
    if ($urandom_range(0, 5) == 0) begin
      pos = int'($urandom_range(0, 3));
      p[8*pos +: 8] = $urandom_range(0, 1) ? 8'($urandom_range(8'h20, 8'h2F))
                                           : 8'($urandom_range(8'h54, 8'h7E));
    end
    return p;
  endfunction

  initial begin
    for (int i = 0; i < NW; i++) begin
      fixedLat[i] = 0;
      forceHit[i] = 1'b0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState();
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] real workers, password 0000");
    workerMode = WM_REAL;
    applyStimulus(32'h30303030);
    waitDone(TIMEOUT);

    $display("[TB] real workers, password SSSS with a start pulse mid-run");
    applyStimulus(32'h53535353);
    repeat (6) @(negedge clk);
    pulseIgnoredStart(32'h30303030);
    waitDone(TIMEOUT);

    $display("[TB] invalid password a123");
    applyStimulus(32'h61313233);
    waitDone(3);

    $display("[TB] workers 1 and 3 hit in the same cycle");
    workerMode = WM_FORCE;
    fixedLat = '{20, 8, 20, 6};
    forceHit = '{1'b0, 1'b1, 1'b0, 1'b1};
    applyStimulus(32'h41424344);
    waitDone(TIMEOUT);

    $display("[TB] workers never find, done after 5 cycles");
    workerMode = WM_NEVER;
    fixedLat = '{5, 5, 5, 5};
    forceHit = '{1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus(32'h37373737);
    waitDone(TIMEOUT);

    $display("[TB] reset mid-run, then restart 0000");
    workerMode = WM_REAL;
    fixedLat = '{0, 0, 0, 0};
    applyStimulus(32'h53535353);
    repeat (5) @(negedge clk);
    pulseIgnoredStart(32'h30303030);
    rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkResetState();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(32'h30303030);
    waitDone(TIMEOUT);

    $display("[TB] randomized passwords");
    for (int t = 0; t < 24; t++) begin
      applyStimulus(randomPassword());
      waitDone(TIMEOUT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule

// File: doc/crack_dispatcher.md
Name: crack_dispatcher

Overview:
- Job-issuing front end for a bank of brute-force password_cracker workers.
- Latches one 4-character target password and splits the 36-value first-digit space into chunks of CHUNK values.
- Issues each chunk as a from/to range to an idle worker, then collects the workers' found/done results.
- Reports one aggregated result: found or exhausted, which worker, and which range.

Parameters:
- NUM_WORKERS, 4, number of attached workers (1..8).
- CHUNK, 4, first-digit values per job (1..36); NUM_JOBS = ceil(36/CHUNK).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- password_in  in  32  four ASCII chars, char0 in [31:24]
- busy  out  1  search in progress
- done  out  1  result valid; held until next accepted start
- found  out  1  password located
- error  out  1  password contains a character outside 0x30..0x53
- found_worker  out  3  index of the reporting worker
- found_from  out  6  from value of the winning job
- cycle_count  out  32  cycles from accept to done
- wk_rst  out  NUM_WORKERS  per-worker active-high reset/load pulse
- wk_password  out  33  password to all workers; bit 32 = 0
- wk_from  out  6*NUM_WORKERS  per-worker range start
- wk_to  out  6*NUM_WORKERS  per-worker range end
- wk_found  in  NUM_WORKERS  worker found flags
- wk_done  in  NUM_WORKERS  worker done flags

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; busy, done, found, error = 0; found_worker, found_from, cycle_count = 0; wk_from/wk_to/wk_password = 0; job index = 0; all worker-busy bits = 0. wk_rst = all-ones while rst is low, which parks the workers.
- IDLE, wk_rst = 0:
  - start=1 latches password_in, clears done/found/error/cycle_count, sets busy, and moves to CHECK.
  - start while busy is ignored.
- CHECK (1 cycle): if any char is < 0x30 or > 0x53, set error=1, done=1, busy=0, and return to IDLE; no worker is touched. Otherwise go to RUN.
- RUN, at most one issue per cycle:
  - If jobs remain and some worker is idle, pick the lowest-index idle worker i and drive for that cycle: wk_rst[i]=1, wk_from[i]=job*CHUNK, wk_to[i]=min(job*CHUNK+CHUNK-1, 35).
  - On the same issue, set busy bit i and a 2-cycle blanking counter for i, then increment job.
  - wk_from, wk_to and wk_password stay stable until worker i is next issued.
  - While worker i's blanking counter is nonzero, its wk_found/wk_done are ignored.
  - Busy worker with wk_found=1 (post-blank): that is a hit. On multiple simultaneous hits the lowest index wins. Register found=1, found_worker=i, found_from=wk_from[i], then go to FINISH.
  - Busy worker with wk_done=1 and wk_found=0: clear busy bit i; that worker is eligible for reissue from the next cycle.
  - A hit outranks any issue or done in the same cycle.
  - Exhaustion: all jobs issued, all busy bits clear, and no hit → found=0, go to FINISH.
- FINISH (1 cycle): done=1, busy=0, go to IDLE. Still-running workers are not reset and their outputs are ignored.
- Latency: found/done are visible 2 cycles after the sampled wk_found edge (hit register, then FINISH).
- cycle_count:
  - Increments every cycle from CHECK through FINISH inclusive.
  - Saturates at 0xFFFF_FFFF.
  - Frozen while done=1.
- Widths: job counter is 6 bits; from/to arithmetic is 6-bit and never exceeds 35.
- Reset mid-operation returns to the reset state within one edge; outputs from the prior search are discarded.

Decomposition:
- Package crack_pkg holds:
  - CHAR_BASE=48, RADIX=36, PWD_CHARS=4, CHAR_MAX=8'h53
  - state enum {IDLE, CHECK, RUN, FINISH}
  - a function for chunk_to(job)
- One sub-module, crack_prio_enc: a parameterised lowest-set-bit encoder with a valid flag. It is instanced twice, once for idle-worker selection and once for hit selection.

Test Plan:
- "0000" with real workers, N=4, CHUNK=4 → found=1, found_worker=0, found_from=0, done=1, error=0.
- "SSSS" → 9 jobs issued in order 0,4,…,32; found=1, found_from=32; wk_to for the last job = 35.
- "a123" (0x61) → error=1, done=1 within 3 cycles of start; wk_rst stays 0 after reset.
- Behavioural worker model, workers 1 and 3 raise wk_found in the same cycle → found_worker=1.
- Model that never finds, done raised 5 cycles after load → all 9 jobs issued, found=0, done=1, busy=0; no reissue to a worker inside its blanking window.
- rst=0 mid-RUN, then "0000" restarted → all outputs 0 during reset; second run matches the first scenario; start pulsed during RUN is ignored.
